// File: rtl/fetch_inst_queue_if.sv
// Fetch-to-decode handshake bundle for the instruction queue.
// master = fetch/decode side driving requests, slave = the queue itself.
interface fetch_inst_queue_if #(
   parameter int unsigned AW = 2
);
   logic          flush;
   logic          in_valid;
   logic          in_ready;
   logic [31:0]   in_pc;
   logic [31:0]   in_inst;
   logic          out_valid;
   logic          out_ready;
   logic [31:0]   out_pc;
   logic [31:0]   out_inst;
   logic [AW:0]   count;

   modport master (
      output flush, in_valid, in_pc, in_inst, out_ready,
      input  in_ready, out_valid, out_pc, out_inst, count
   );

   modport slave (
      input  flush, in_valid, in_pc, in_inst, out_ready,
      output in_ready, out_valid, out_pc, out_inst, count
   );
endinterface

// File: rtl/fetch_inst_queue.sv
// Circular FIFO of {pc, inst} pairs between fetch and decode, with flush on redirect.
// Define IFQ_BYPASS_EN for a zero-latency combinational path through an empty queue.
module fetch_inst_queue #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned AW    = 2
) (
   input logic              clk,
   input logic              rst,
   fetch_inst_queue_if.slave ifq
);

   logic [63:0] mem_q [DEPTH];
   logic [AW:0] wr_ptr_q, rd_ptr_q;
   logic        empty, full, push, pop, bypass, wr_en, rd_en;
   logic [63:0] head;

   always_comb begin
      empty = (wr_ptr_q == rd_ptr_q);
      full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
      head  = mem_q[rd_ptr_q[AW-1:0]];

      ifq.in_ready = !full && !ifq.flush;
      push         = ifq.in_valid && ifq.in_ready;
`ifdef IFQ_BYPASS_EN
      bypass = empty && ifq.in_valid && !ifq.flush;
`else
      bypass = 1'b0;
`endif
      ifq.out_valid = (!empty || bypass) && !ifq.flush;
      pop           = ifq.out_valid && ifq.out_ready;

      // A bypassed entry consumed the same cycle never touches storage.
      wr_en = push && !(bypass && ifq.out_ready);
      rd_en = pop && !empty;

      if (!ifq.out_valid) begin
         ifq.out_pc   = 32'h0;
         ifq.out_inst = 32'h0;
      end else if (empty) begin
         ifq.out_pc   = ifq.in_pc;
         ifq.out_inst = ifq.in_inst;
      end else begin
         ifq.out_pc   = head[63:32];
         ifq.out_inst = head[31:0];
      end

      ifq.count = wr_ptr_q - rd_ptr_q;
   end

   always_ff @(posedge clk) begin
      if (rst || ifq.flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   // Storage is deliberately left uncleared by reset; pointers define validity.
   always_ff @(posedge clk) begin
      if (wr_en && !rst) mem_q[wr_ptr_q[AW-1:0]] <= {ifq.in_pc, ifq.in_inst};
   end

endmodule

// File: tb/tb_fetch_inst_queue.sv
// Randomized and directed checks of fetch_inst_queue against a queue-based model.
module tb_fetch_inst_queue;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned AW    = 2;
`ifdef IFQ_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   int   n_vec = 0;
   int   n_err = 0;
   logic [63:0] mdl_q [$];

   fetch_inst_queue_if #(.AW(AW)) ifq ();

   fetch_inst_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk (clk),
      .rst (rst),
      .ifq (ifq)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic drive(input bit v, input logic [31:0] pc, input logic [31:0] inst,
                        input bit rdy, input bit fl);
      ifq.in_valid  = v;
      ifq.in_pc     = pc;
      ifq.in_inst   = inst;
      ifq.out_ready = rdy;
      ifq.flush     = fl;
   endtask

   // Check outputs mid-cycle against the model, then advance model and DUT by one edge.
   task automatic step();
      int   sz;
      bit   exp_in_ready, exp_out_valid, do_push, do_pop;
      logic [63:0] exp_data;
      @(negedge clk);
      sz            = mdl_q.size();
      exp_in_ready  = !ifq.flush && (sz < DEPTH);
      exp_out_valid = !ifq.flush && (sz > 0 || (BYP && ifq.in_valid));
      if (!exp_out_valid)  exp_data = 64'h0;
      else if (sz > 0)     exp_data = mdl_q[0];
      else                 exp_data = {ifq.in_pc, ifq.in_inst};
      check_val("in_ready",  64'(ifq.in_ready),  64'(exp_in_ready));
      check_val("out_valid", 64'(ifq.out_valid), 64'(exp_out_valid));
      check_val("out_data",  {ifq.out_pc, ifq.out_inst}, exp_data);
      check_val("count",     64'(ifq.count),     64'(sz));
      if (rst || ifq.flush) begin
         mdl_q.delete();
      end else begin
         do_push = ifq.in_valid && exp_in_ready;
         do_pop  = exp_out_valid && ifq.out_ready;
         if (do_pop && sz > 0) void'(mdl_q.pop_front());
         if (do_push && !(do_pop && sz == 0)) mdl_q.push_back({ifq.in_pc, ifq.in_inst});
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      mdl_q.delete();
      check_val("rst_out_inst", 64'(ifq.out_inst), 64'h0);
      step();

      // Fill to full with decode stalled; fifth offer must be ignored.
      for (int i = 1; i <= 5; i++) begin
         drive(1'b1, 32'(i), 32'h05110003 + 32'(i - 1), 1'b0, 1'b0);
         step();
      end
      check_val("fill_count", 64'(ifq.count), 64'd4);
      // Full with pop: head leaves, nothing enters; then push lands.
      drive(1'b1, 32'h100, 32'hAAAA0000, 1'b1, 1'b0);
      step();
      check_val("fullpop_count", 64'(ifq.count), 64'd3);
      drive(1'b1, 32'h101, 32'hAAAA0001, 1'b0, 1'b0);
      step();
      check_val("refill_count", 64'(ifq.count), 64'd4);
      // Drain in order.
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
         step();
      end

      // Streaming through with simultaneous push/pop to wrap pointers.
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, 32'h200 + 32'(i), 32'h0BAD0000 + 32'(i), 1'b1, 1'b0);
         step();
      end
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      step();

      // Flush with three queued and an offered instruction.
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 32'h300 + 32'(i), 32'hF1000000 + 32'(i), 1'b0, 1'b0);
         step();
      end
      drive(1'b1, 32'h3FF, 32'hDEADBEEF, 1'b1, 1'b1);
      step();
      check_val("flush_count", 64'(ifq.count), 64'd0);
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      step();

      // Bypass case on empty queue.
      drive(1'b1, 32'h400, 32'h07b80000, 1'b1, 1'b0);
      step();
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      step();

      // Random traffic, including occasional flush and mid-stream reset.
      for (int i = 0; i < 600; i++) begin
         drive($urandom_range(0, 3) != 0, $urandom, $urandom,
               $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
         rst = ($urandom_range(0, 63) == 0);
         step();
      end
      rst = 1'b0;
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      repeat (6) step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
